// File: rtl/qcl_div_pkg.sv
// Shared types and helpers for the qcl_div radix-2 restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package qcl_div_pkg;

   // Controller states: accept a request, iterate one quotient bit per
   // cycle, then hold the result until the consumer takes it.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the step counter. It must hold width_p-1, and it is never
   // narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/qcl_div_if.sv
// Request/response bundle of the divider: valid/ready in, valid/yumi out.
// Latency: n/a (wiring only).
// Backpressure: consumer stalls results by withholding yumi_i.
interface qcl_div_if #(
   parameter int width_p = 32
);
   logic               v_i;
   logic               ready_o;
   logic               signed_i;
   logic [width_p-1:0] dividend_i;
   logic [width_p-1:0] divisor_i;
   logic               v_o;
   logic               yumi_i;
   logic [width_p-1:0] quotient_o;
   logic [width_p-1:0] remainder_o;
   logic               div_by_zero_o;

   // Requester / consumer side.
   modport master (
      output v_i, signed_i, dividend_i, divisor_i, yumi_i,
      input  ready_o, v_o, quotient_o, remainder_o, div_by_zero_o
   );

   // Divider side.
   modport slave (
      input  v_i, signed_i, dividend_i, divisor_i, yumi_i,
      output ready_o, v_o, quotient_o, remainder_o, div_by_zero_o
   );
endinterface

// File: rtl/qcl_div_abs.sv
// Conditional two's-complement negate: data_o = neg_i ? -data_i : data_i.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module qcl_div_abs #(
   parameter int width_p = 32
) (
   input  logic               neg_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   logic [width_p-1:0] w_neg;

   // Negating -2^(width_p-1) wraps to itself; read unsigned it is the
   // correct magnitude 2^(width_p-1), so no extra bit is required.
   assign w_neg  = ~data_i + width_p'(1);
   assign data_o = neg_i ? w_neg : data_i;

endmodule

// File: rtl/qcl_div.sv
// Iterative radix-2 restoring divider: q = a/b, r = a%b, signed or unsigned.
// Latency: exactly width_p cycles from accept edge to v_o; II >= width_p+2.
// Backpressure: ready_o only in IDLE; result held in DONE until yumi_i.
module qcl_div
   import qcl_div_pkg::*;
#(
   parameter int width_p = 32
) (
   input  logic     clk_i,
   input  logic     reset_n_i,
   qcl_div_if.slave bus
);

   localparam int CNT_W = cnt_width(width_p);

   // Controller state.
   state_e             r_state;
   state_e             w_state_nxt;
   logic               w_ready;
   logic               w_valid;

   // Iteration registers: r_quo starts as |a| and is shifted out MSB first
   // while quotient bits are shifted in at the LSB.
   logic [CNT_W-1:0]   r_cnt;
   logic [width_p-1:0] r_rem;
   logic [width_p-1:0] r_quo;
   logic [width_p-1:0] r_dvsr;
   logic [width_p-1:0] r_dvnd_raw;
   logic               r_sign_q;
   logic               r_sign_r;
   logic               r_signed;
   logic               r_zero;

   // Result registers, stable for as long as the result is presented.
   logic [width_p-1:0] r_quotient;
   logic [width_p-1:0] r_remainder;
   logic               r_dbz;

   // Operand magnitudes at accept.
   logic               w_sa;
   logic               w_sb;
   logic [width_p-1:0] w_abs_a;
   logic [width_p-1:0] w_abs_b;

   // One restoring step.
   logic [width_p:0]   w_shift;
   logic [width_p:0]   w_trial;
   logic               w_qbit;
   logic [width_p-1:0] w_rem_nxt;
   logic [width_p-1:0] w_quo_nxt;

   // Sign-corrected results of the final step.
   logic [width_p-1:0] w_q_fix;
   logic [width_p-1:0] w_r_fix;

   assign w_sa = bus.signed_i & bus.dividend_i[width_p-1];
   assign w_sb = bus.signed_i & bus.divisor_i[width_p-1];

   qcl_div_abs #(.width_p(width_p)) u_abs_a (
      .neg_i  (w_sa),
      .data_i (bus.dividend_i),
      .data_o (w_abs_a)
   );

   qcl_div_abs #(.width_p(width_p)) u_abs_b (
      .neg_i  (w_sb),
      .data_i (bus.divisor_i),
      .data_o (w_abs_b)
   );

   // Partial remainder is always below the divisor, so the shifted value is
   // below 2*divisor and the trial difference fits width_p+1 bits; its MSB
   // is the borrow that says whether the divisor fitted.
   assign w_shift   = {r_rem, r_quo[width_p-1]};
   assign w_trial   = w_shift - {1'b0, r_dvsr};
   assign w_qbit    = ~w_trial[width_p];
   assign w_rem_nxt = w_qbit ? w_trial[width_p-1:0] : w_shift[width_p-1:0];
   assign w_quo_nxt = {r_quo[width_p-2:0], w_qbit};

   // Quotient negative when operand signs differ; remainder follows the
   // dividend (truncating division). Both only in signed mode.
   qcl_div_abs #(.width_p(width_p)) u_fix_q (
      .neg_i  (r_signed & r_sign_q),
      .data_i (w_quo_nxt),
      .data_o (w_q_fix)
   );

   qcl_div_abs #(.width_p(width_p)) u_fix_r (
      .neg_i  (r_signed & r_sign_r),
      .data_i (w_rem_nxt),
      .data_o (w_r_fix)
   );

   // State register; reset aborts any in-flight division immediately.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_valid     = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (bus.v_i) begin
               w_state_nxt = CALC;
            end
         end
         CALC: begin
            if (r_cnt == '0) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_valid = 1'b1;
            if (bus.yumi_i) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: capture at accept, iterate in CALC, publish on the last step.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvsr      <= '0;
         r_dvnd_raw  <= '0;
         r_sign_q    <= 1'b0;
         r_sign_r    <= 1'b0;
         r_signed    <= 1'b0;
         r_zero      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.v_i) begin
                  r_cnt      <= CNT_W'(width_p - 1);
                  r_rem      <= '0;
                  r_quo      <= w_abs_a;
                  r_dvsr     <= w_abs_b;
                  r_dvnd_raw <= bus.dividend_i;
                  r_sign_q   <= bus.dividend_i[width_p-1] ^ bus.divisor_i[width_p-1];
                  r_sign_r   <= bus.dividend_i[width_p-1];
                  r_signed   <= bus.signed_i;
                  r_zero     <= (bus.divisor_i == '0);
               end
            end
            CALC: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else if (r_zero) begin
                  // Divide by zero: all-ones quotient, untouched dividend.
                  r_quotient  <= '1;
                  r_remainder <= r_dvnd_raw;
                  r_dbz       <= 1'b1;
               end else begin
                  // Signed overflow (-2^(w-1) / -1) falls out of the
                  // magnitude path as q = 2^(w-1), r = 0 with no fixup.
                  r_quotient  <= w_q_fix;
                  r_remainder <= w_r_fix;
                  r_dbz       <= 1'b0;
               end
            end
            default: begin
               // DONE: hold everything until the consumer takes the result.
            end
         endcase
      end
   end

   assign bus.ready_o       = w_ready;
   assign bus.v_o           = w_valid;
   assign bus.quotient_o    = r_quotient;
   assign bus.remainder_o   = r_remainder;
   assign bus.div_by_zero_o = r_dbz;

endmodule

// File: tb/tb_qcl_div.sv
// Self-checking bench for qcl_div at width_p=8: directed cases, stalls,
// mid-operation reset and randomized requests against an arithmetic model.
module tb_qcl_div;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   qcl_div_if #(.width_p(W)) bus ();

   qcl_div #(.width_p(W)) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic       z;
   } dcase_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer division in 64-bit arithmetic, truncated.
   function automatic void model(input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 output logic [W-1:0] q,
                                 output logic [W-1:0] r,
                                 output logic z);
      longint la;
      longint lb;
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else begin
         if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
         end else begin
            la = longint'(a);
            lb = longint'(b);
         end
         q = W'(la / lb);
         r = W'(la % lb);
         z = 1'b0;
      end
   endfunction

   // Issue one request, check latency, wait 'hold' cycles, take the result.
   task automatic run_req(input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z);
      int guard;
      int lat;
      guard = 0;
      while (bus.ready_o !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      checks++;
      if (bus.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL ready_wait: ready_o=%b required 1", bus.ready_o);
      end
      bus.signed_i   = s;
      bus.dividend_i = a;
      bus.divisor_i  = b;
      bus.v_i        = 1'b1;
      tick();
      bus.v_i = 1'b0;
      lat = 0;
      while (bus.v_o !== 1'b1 && lat < W + 4) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != W) begin
         errors++;
         $display("FAIL latency: got %0d cycles required %0d", lat, W);
      end
      repeat (hold) tick();
      q = bus.quotient_o;
      r = bus.remainder_o;
      z = bus.div_by_zero_o;
      checks++;
      if (bus.v_o !== 1'b1) begin
         errors++;
         $display("FAIL yumi_legal: yumi with v_o=%b required 1", bus.v_o);
      end
      bus.yumi_i = 1'b1;
      tick();
      bus.yumi_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.v_i        = 1'b0;
      bus.yumi_i     = 1'b0;
      bus.signed_i   = 1'b0;
      bus.dividend_i = '0;
      bus.divisor_i  = '0;
      repeat (3) tick();
      checks++;
      if (bus.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b required 1", bus.ready_o);
      end
      checks++;
      if (bus.v_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_v_o: got %b required 0", bus.v_o);
      end
      checks++;
      if (bus.quotient_o !== '0 || bus.remainder_o !== '0 || bus.div_by_zero_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: q=%h r=%h z=%b required 0/0/0",
                  bus.quotient_o, bus.remainder_o, bus.div_by_zero_o);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      dcase_t tbl[7];
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic z;
      tbl[0] = '{"u100_7",   1'b0, 8'd100, 8'd7,   8'h0E, 8'h02, 1'b0};
      tbl[1] = '{"s-100_7",  1'b1, 8'h9C,  8'h07,  8'hF2, 8'hFE, 1'b0};
      tbl[2] = '{"s100_-7",  1'b1, 8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0};
      tbl[3] = '{"u5_0",     1'b0, 8'h05,  8'h00,  8'hFF, 8'h05, 1'b1};
      tbl[4] = '{"s-5_0",    1'b1, 8'hFB,  8'h00,  8'hFF, 8'hFB, 1'b1};
      tbl[5] = '{"s_ovf",    1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0};
      tbl[6] = '{"u80_ff",   1'b0, 8'h80,  8'hFF,  8'h00, 8'h80, 1'b0};
      for (int i = 0; i < 7; i++) begin
         run_req(tbl[i].s, tbl[i].a, tbl[i].b, 1, q, r, z);
         checks++;
         if (q !== tbl[i].q || r !== tbl[i].r || z !== tbl[i].z) begin
            errors++;
            $display("FAIL dir_%s: q=%h r=%h z=%b required q=%h r=%h z=%b",
                     tbl[i].name, q, r, z, tbl[i].q, tbl[i].r, tbl[i].z);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic ez;
      int guard;
      model(1'b0, 8'd200, 8'd9, eq, er, ez);
      bus.signed_i   = 1'b0;
      bus.dividend_i = 8'd200;
      bus.divisor_i  = 8'd9;
      bus.v_i        = 1'b1;
      tick();
      bus.v_i = 1'b0;
      guard = 0;
      while (bus.v_o !== 1'b1 && guard < W + 4) begin
         tick();
         guard++;
      end
      for (int i = 0; i < 5; i++) begin
         bus.v_i        = ~bus.v_i;
         bus.signed_i   = 1'($urandom_range(0, 1));
         bus.dividend_i = W'($urandom);
         bus.divisor_i  = W'($urandom);
         tick();
         checks++;
         if (bus.v_o !== 1'b1 || bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_hs_%0d: v_o=%b ready_o=%b required 1/0", i, bus.v_o, bus.ready_o);
         end
         checks++;
         if (bus.quotient_o !== eq || bus.remainder_o !== er || bus.div_by_zero_o !== ez) begin
            errors++;
            $display("FAIL bp_hold_%0d: q=%h r=%h z=%b required q=%h r=%h z=%b", i,
                     bus.quotient_o, bus.remainder_o, bus.div_by_zero_o, eq, er, ez);
         end
      end
      bus.v_i    = 1'b0;
      bus.yumi_i = 1'b1;
      tick();
      bus.yumi_i = 1'b0;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.v_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: ready_o=%b v_o=%b required 1/0", bus.ready_o, bus.v_o);
      end
      tick();
      checks++;
      if (bus.ready_o !== 1'b1 || bus.v_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_accept: ready_o=%b v_o=%b required 1/0", bus.ready_o, bus.v_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic z;
      bus.signed_i   = 1'b0;
      bus.dividend_i = 8'd50;
      bus.divisor_i  = 8'd3;
      bus.v_i        = 1'b1;
      tick();
      bus.v_i = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.v_o !== 1'b0 || bus.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_hs: v_o=%b ready_o=%b required 0/1", bus.v_o, bus.ready_o);
      end
      checks++;
      if (bus.quotient_o !== '0 || bus.remainder_o !== '0 || bus.div_by_zero_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_out: q=%h r=%h z=%b required 0/0/0",
                  bus.quotient_o, bus.remainder_o, bus.div_by_zero_o);
      end
      tick();
      rst_n = 1'b1;
      tick();
      run_req(1'b0, 8'd255, 8'd16, 0, q, r, z);
      checks++;
      if (q !== 8'd15 || r !== 8'd15 || z !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_next: q=%h r=%h z=%b required 0f/0f/0", q, r, z);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic s;
      logic z;
      logic ez;
      int sel;
      for (int n = 0; n < 1000; n++) begin
         s   = 1'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 9));
         a   = (sel == 1) ? 8'h80 : W'($urandom);
         case (sel)
            0:       b = '0;
            1, 2:    b = 8'hFF;
            3:       b = 8'h01;
            default: b = W'($urandom);
         endcase
         model(s, a, b, eq, er, ez);
         run_req(s, a, b, int'($urandom_range(0, 3)), q, r, z);
         checks++;
         if (q !== eq || r !== er || z !== ez) begin
            errors++;
            $display("FAIL rand_%0d: s=%b a=%h b=%h got q=%h r=%h z=%b required q=%h r=%h z=%b",
                     n, s, a, b, q, r, z, eq, er, ez);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
